se_selfcomp_leak_monitor: RTL

- Output-side responder for a self-composed pair of SE execution units.
- Drives the shared io_out_ready and consumes both result streams in lockstep.
- Measures per-transaction completion skew between the two copies and raises timingLeak on any divergence.
- Sits between the two SE instances and the formal/simulation harness; timingLeakDone marks the end of a run.

---
 rtl/se_selfcomp_leak_monitor.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/se_selfcomp_leak_monitor.sv
// Output-side responder for a self-composed pair of SE execution units.
// Consumes both result streams in lockstep and flags timing divergence.
//
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   io_start               : pulse that arms a run (from IDLE or DONE)
//   io_out_validOne/Two    : result valid from each copy
//   io_out_resultOne/Two   : result data from each copy
//   io_out_cntrOne/Two     : SE internal cycle counts
//   io_out_ready           : shared ready, high only on a joint handshake
//   bothValid              : validOne & validTwo
//   timingLeak             : sticky, timing divergence seen this run
//   timingLeakDone         : high while the run is finished
//   resultMismatch         : sticky, results differed on a handshake
//   protocolError          : sticky, early valid dropped while skewed
//   leakLane               : first early lane (01 one, 10 two)
//   maxSkew                : largest skew observed, saturating
//   txnCount               : handshakes completed this run
module se_selfcomp_leak_monitor #(
    parameter int DATA_W  = 128,
    parameter int CNTR_W  = 8,
    parameter int NUM_TXN = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_start,
    input  logic              io_out_validOne,
    input  logic              io_out_validTwo,
    input  logic [DATA_W-1:0] io_out_resultOne,
    input  logic [DATA_W-1:0] io_out_resultTwo,
    input  logic [CNTR_W-1:0] io_out_cntrOne,
    input  logic [CNTR_W-1:0] io_out_cntrTwo,
    output logic              io_out_ready,
    output logic              bothValid,
    output logic              timingLeak,
    output logic              timingLeakDone,
    output logic              resultMismatch,
    output logic              protocolError,
    output logic [1:0]        leakLane,
    output logic [CNTR_W-1:0] maxSkew,
    output logic [7:0]        txnCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SKEW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0]        NUM_TXN_C = 8'(NUM_TXN);
    localparam logic [CNTR_W-1:0] TIMEOUT_C = CNTR_W'(TIMEOUT);
    localparam logic [CNTR_W-1:0] SKEW_MAX  = '1;

    state_t            state, state_d;
    logic [CNTR_W-1:0] skew, skew_d;
    // 0: lane one arrived first, 1: lane two arrived first
    logic              early, early_d;
    logic              leak_d, mism_d, perr_d;
    logic [1:0]        lane_d;
    logic [CNTR_W-1:0] max_d;
    logic [7:0]        txn_d;
    logic              one_valid;
    logic              early_v, late_v;

    assign bothValid      = io_out_validOne & io_out_validTwo;
    assign one_valid      = io_out_validOne ^ io_out_validTwo;
    assign timingLeakDone = (state == DONE);
    assign early_v        = early ? io_out_validTwo : io_out_validOne;
    assign late_v         = early ? io_out_validOne : io_out_validTwo;

    always_comb begin
        state_d      = state;
        skew_d       = skew;
        early_d      = early;
        leak_d       = timingLeak;
        mism_d       = resultMismatch;
        perr_d       = protocolError;
        lane_d       = leakLane;
        max_d        = maxSkew;
        txn_d        = txnCount;
        io_out_ready = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                // a new run wipes every result of the previous one
                if (io_start) begin
                    state_d = ARMED;
                    skew_d  = '0;
                    early_d = 1'b0;
                    leak_d  = 1'b0;
                    mism_d  = 1'b0;
                    perr_d  = 1'b0;
                    lane_d  = 2'b00;
                    max_d   = '0;
                    txn_d   = '0;
                end
            end
            ARMED: begin
                io_out_ready = bothValid;
                if (bothValid) begin
                    txn_d = txnCount + 8'd1;
                    if (io_out_cntrOne != io_out_cntrTwo) leak_d = 1'b1;
                    if (io_out_resultOne != io_out_resultTwo) mism_d = 1'b1;
                    if (txnCount + 8'd1 == NUM_TXN_C) state_d = DONE;
                end else if (one_valid) begin
                    state_d = SKEW;
                    skew_d  = {{(CNTR_W-1){1'b0}}, 1'b1};
                    leak_d  = 1'b1;
                    early_d = io_out_validTwo;
                    if (leakLane == 2'b00)
                        lane_d = io_out_validOne ? 2'b01 : 2'b10;
                end
            end
            SKEW: begin
                if (!early_v) begin
                    perr_d  = 1'b1;
                    state_d = DONE;
                end else if (late_v) begin
                    // handshake follows in the next ARMED cycle
                    state_d = ARMED;
                    max_d   = (skew > maxSkew) ? skew : maxSkew;
                end else if (skew >= TIMEOUT_C) begin
                    max_d   = TIMEOUT_C;
                    state_d = DONE;
                end else if (skew != SKEW_MAX) begin
                    skew_d = skew + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            skew           <= '0;
            early          <= 1'b0;
            timingLeak     <= 1'b0;
            resultMismatch <= 1'b0;
            protocolError  <= 1'b0;
            leakLane       <= 2'b00;
            maxSkew        <= '0;
            txnCount       <= '0;
        end else begin
            state          <= state_d;
            skew           <= skew_d;
            early          <= early_d;
            timingLeak     <= leak_d;
            resultMismatch <= mism_d;
            protocolError  <= perr_d;
            leakLane       <= lane_d;
            maxSkew        <= max_d;
            txnCount       <= txn_d;
        end
    end

endmodule
